// File: rtl/enc_edge_counter.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : enc_edge_counter
// Description : Counts edges of an asynchronous encoder pin. The pin is
//               synchronized, debounced by a FILT_LEN-sample stability
//               filter, edge-detected and counted. A snapshot register gives
//               a bus reader a stable copy of the count, and a sticky flag
//               records counter wrap.
// Options     : ENC_BOTH_EDGES_EN - when defined, both rising and falling
//               edges of the filtered level are counted; otherwise only
//               rising edges are counted. The port list is the same in both.
// Revision    : 1.0 - initial release
//==============================================================================
module enc_edge_counter #(
  parameter int FILT_LEN = 4,   // consecutive disagreeing samples (1..15)
  parameter int CNT_W    = 16   // width of count and snapshot
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_in,
  input  logic             clr,
  input  logic             snap_req,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] snap,
  output logic             snap_valid,
  output logic             ovf
);

  // The filter switches on the FILT_LEN-th consecutive disagreeing sample,
  // i.e. in the cycle where the stability counter would reach FILT_LEN.
  localparam logic [3:0] c_filt_last = 4'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  // Synchronizer, filter and edge-detect state
  logic             r_sync1;
  logic             r_sync2;
  logic             r_lvl;
  logic             r_lvl_prev;
  logic [3:0]       r_stab;

  // Counter and snapshot state
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_snap;
  logic             r_snap_valid;
  logic             r_ovf;

  // Combinational decode
  logic             w_stab_done;
  logic             w_rise;
  logic             w_edge;
  logic             w_wrap;

  assign w_stab_done = (r_stab == c_filt_last);
  assign w_rise      = r_lvl & ~r_lvl_prev;

`ifdef ENC_BOTH_EDGES_EN
  logic             w_fall;
  assign w_fall = ~r_lvl & r_lvl_prev;
  assign w_edge = w_rise | w_fall;
`else
  assign w_edge = w_rise;
`endif

  // A counted edge while the counter is all-ones is a wrap to zero
  assign w_wrap = w_edge & (r_count == {CNT_W{1'b1}});

  // Two-flop synchronizer for the asynchronous encoder pin; its zero reset
  // state also keeps any count change at least 2+FILT_LEN+1 cycles after
  // reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= enc_in;
      r_sync2 <= r_sync1;
    end
  end

  // Stability filter: level follows the sample only after FILT_LEN
  // consecutive disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl  <= 1'b0;
      r_stab <= 4'd0;
    end else if (r_sync2 != r_lvl) begin
      if (w_stab_done) begin
        r_lvl  <= r_sync2;
        r_stab <= 4'd0;
      end else begin
        r_stab <= r_stab + 4'd1;
      end
    end else begin
      r_stab <= 4'd0;
    end
  end

  // Previous filtered level, used to form the one-cycle edge strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl_prev <= 1'b0;
    end else begin
      r_lvl_prev <= r_lvl;
    end
  end

  // Edge counter; clear wins over a same-cycle edge, which is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (w_edge) begin
      r_count <= r_count + c_cnt_one;
    end
  end

  // Sticky wrap flag; clear wins even over a same-cycle wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_ovf <= 1'b0;
    end else if (w_wrap) begin
      r_ovf <= 1'b1;
    end
  end

  // Snapshot captures the pre-update count; clr leaves it untouched.
  // The valid pulse follows every request by one cycle, so back-to-back
  // requests give back-to-back pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap       <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      r_snap_valid <= snap_req;
      if (snap_req) begin
        r_snap <= r_count;
      end
    end
  end

  assign count      = r_count;
  assign snap       = r_snap;
  assign snap_valid = r_snap_valid;
  assign ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_enc_edge_counter.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_enc_edge_counter
// Description : Directed self-checking bench for enc_edge_counter. A second
//               8-bit instance shares all stimulus so counter wrap can be
//               reached in a short run.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_enc_edge_counter;

`ifdef ENC_BOTH_EDGES_EN
  localparam int K = 2;
`else
  localparam int K = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        enc_in;
  logic        clr;
  logic        snap_req;

  logic [15:0] count;
  logic [15:0] snap;
  logic        snap_valid;
  logic        ovf;

  logic [7:0]  w_count;
  logic [7:0]  w_snap;
  logic        w_snap_valid;
  logic        w_ovf;

  int          total;
  int          bad;

  enc_edge_counter #(.FILT_LEN(4), .CNT_W(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enc_in     (enc_in),
    .clr        (clr),
    .snap_req   (snap_req),
    .count      (count),
    .snap       (snap),
    .snap_valid (snap_valid),
    .ovf        (ovf)
  );

  enc_edge_counter #(.FILT_LEN(4), .CNT_W(8)) u_w (
    .clk        (clk),
    .rst_n      (rst_n),
    .enc_in     (enc_in),
    .clr        (clr),
    .snap_req   (snap_req),
    .count      (w_count),
    .snap       (w_snap),
    .snap_valid (w_snap_valid),
    .ovf        (w_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // One clean pulse starting at a falling clock edge
  task automatic pulse(input int h, input int l);
    enc_in = 1'b1;
    repeat (h) @(negedge clk);
    enc_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic flush();
    repeat (12) @(negedge clk);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    enc_in   = 1'b0;
    clr      = 1'b0;
    snap_req = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_snap", snap, 0);
    chk("rst_snap_valid", snap_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_w_count", w_count, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 3-cycle glitch is rejected
    enc_in = 1'b1;
    repeat (3) @(negedge clk);
    enc_in = 1'b0;
    flush();
    chk("glitch_count", count, 0);

    // 4-cycle pulse counts exactly 7 cycles after the rising transition
    enc_in = 1'b1;
    repeat (4) @(negedge clk);
    enc_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("lat6_count", count, 0);
    @(posedge clk);
    #1 chk("lat7_count", count, 1);
    @(negedge clk);
    flush();
    chk("pulse4_count", count, K);

    // clr zeroes count
    do_clr();
    chk("clr_count", count, 0);
    chk("clr_ovf", ovf, 0);

    // 10 clean pulses, 8 high / 8 low
    for (int i = 0; i < 10; i++) pulse(8, 8);
    flush();
    chk("ten_pulses", count, 10 * K);

    // clr in the same cycle as the edge strobe drops the edge
    enc_in = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_clr_edge", count, 10 * K);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_edge_count", count, 0);
    repeat (3) @(negedge clk);
    chk("clr_edge_after", count, 0);
    enc_in = 1'b0;
    flush();
    do_clr();
    chk("clr2_count", count, 0);

    // Wrap on the 8-bit instance
    for (int i = 0; i < 255; i++) pulse(4, 4);
    flush();
    chk("w_pre_wrap", w_count, 8'hFF);
    chk("w_pre_wrap_ovf", w_ovf, 0);
    pulse(4, 4);
    flush();
    chk("w_wrap_count", w_count, 0);
    chk("w_wrap_ovf", w_ovf, 1);
    chk("main_256", count, 16'h0100);
    chk("main_no_ovf", ovf, 0);
    do_clr();
    chk("w_clr_ovf", w_ovf, 0);
    chk("w_clr_count", w_count, 0);

    // clr and wrap in the same cycle leave ovf clear
    for (int i = 0; i < 255; i++) pulse(4, 4);
    flush();
    chk("w_pre_wrap2", w_count, 8'hFF);
    enc_in = 1'b1;
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("w_clrwrap_count", w_count, 0);
    chk("w_clrwrap_ovf", w_ovf, 0);
    chk("clrwrap_main", count, 0);
    enc_in = 1'b0;
    flush();

    // Snapshot in the same cycle as an edge, count 0x01FF
    for (int i = 0; i < 511; i++) pulse(4, 4);
    flush();
    chk("pre_snap_count", count, 16'h01FF);
    chk("snap_held_zero", snap, 0);
    enc_in = 1'b1;
    repeat (6) @(negedge clk);
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    chk("snap_edge_snap", snap, 16'h01FF);
    chk("snap_edge_count", count, 16'h0200);
    chk("snap_edge_valid", snap_valid, 1);
    @(negedge clk);
    chk("snap_valid_drop", snap_valid, 0);
    enc_in = 1'b0;
    flush();

    // Back-to-back requests straddling an edge
    enc_in = 1'b1;
    repeat (5) @(negedge clk);
    snap_req = 1'b1;
    @(negedge clk);
    chk("b2b1_snap", snap, 16'h0200);
    chk("b2b1_valid", snap_valid, 1);
    @(negedge clk);
    chk("b2b2_snap", snap, 16'h0200);
    chk("b2b2_valid", snap_valid, 1);
    chk("b2b2_count", count, 16'h0201);
    @(negedge clk);
    snap_req = 1'b0;
    chk("b2b3_snap", snap, 16'h0201);
    chk("b2b3_valid", snap_valid, 1);
    @(negedge clk);
    chk("b2b_valid_drop", snap_valid, 0);
    chk("b2b_hold", snap, 16'h0201);
    enc_in = 1'b0;
    flush();

    // clr leaves snap alone
    do_clr();
    chk("clr_keep_snap", snap, 16'h0201);
    chk("clr3_count", count, 0);

    // Reset mid-filter with count 0x1234
    for (int i = 0; i < 16'h1234; i++) pulse(4, 4);
    flush();
    chk("pre_rst_count", count, 16'h1234);
    chk("pre_rst_w_ovf", w_ovf, 1);
    enc_in = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("inrst_count", count, 0);
    chk("inrst_snap", snap, 0);
    chk("inrst_ovf", ovf, 0);
    chk("inrst_w_ovf", w_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("rel6_count", count, 0);
    chk("rel6_snap_valid", snap_valid, 0);
    @(posedge clk);
    #1 chk("rel7_count", count, 1);
    @(negedge clk);
    enc_in = 1'b0;
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
